// File: rtl/first_nios2_system_sysinfo.sv
// System-information slave: ID, build timestamp, 64-bit prescaled uptime with
// coherent high-word shadow, scratch, control and prescale registers.
// Reads return one cycle after the strobe with readdatavalid.
module first_nios2_system_sysinfo #(
  parameter logic [31:0] SYSTEM_ID        = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP        = 32'd1521037506,
  parameter logic [31:0] PRESCALE_DEFAULT = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [2:0] ADDR_ID       = 3'd0;
  localparam logic [2:0] ADDR_TSTAMP   = 3'd1;
  localparam logic [2:0] ADDR_UP_LO    = 3'd2;
  localparam logic [2:0] ADDR_UP_HI    = 3'd3;
  localparam logic [2:0] ADDR_SCRATCH  = 3'd4;
  localparam logic [2:0] ADDR_CTRL     = 3'd5;
  localparam logic [2:0] ADDR_PRESCALE = 3'd6;

  logic [63:0] uptime;
  logic [31:0] pcnt;
  logic [31:0] hi_shadow;
  logic [31:0] scratch;
  logic [31:0] prescale;
  logic        en;

  logic        wr_ctrl;
  logic        wr_prescale;
  logic        wr_scratch;
  logic        clr;
  logic        en_next;
  logic        tick;
  logic [31:0] rd_mux;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // Decode write strobes; a CTRL write changes EN on the same edge it lands,
  // so the prescaler already sees the new EN value.
  always_comb begin
    wr_ctrl     = write && (address == ADDR_CTRL) && byteenable[0];
    wr_prescale = write && (address == ADDR_PRESCALE);
    wr_scratch  = write && (address == ADDR_SCRATCH);
    clr         = wr_ctrl && writedata[1];
    en_next     = wr_ctrl ? writedata[0] : en;
    tick        = en_next && (pcnt == prescale);
  end

  // Read mux over pre-edge register values.
  always_comb begin
    rd_mux = 32'd0;
    case (address)
      ADDR_ID:       rd_mux = SYSTEM_ID;
      ADDR_TSTAMP:   rd_mux = TIMESTAMP;
      ADDR_UP_LO:    rd_mux = uptime[31:0];
      ADDR_UP_HI:    rd_mux = hi_shadow;
      ADDR_SCRATCH:  rd_mux = scratch;
      ADDR_CTRL:     rd_mux = {31'd0, en};
      ADDR_PRESCALE: rd_mux = prescale;
      default:       rd_mux = 32'd0;
    endcase
  end

  // Prescaler and uptime counter; clear wins over a coincident tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uptime <= 64'd0;
      pcnt   <= 32'd0;
      en     <= 1'b1;
    end else begin
      en <= en_next;
      if (clr) begin
        uptime <= 64'd0;
        pcnt   <= 32'd0;
      end else begin
        if (tick) uptime <= uptime + 64'd1;
        if (wr_prescale || tick) pcnt <= 32'd0;
        else if (en_next)        pcnt <= pcnt + 32'd1;
      end
    end
  end

  // Byte-enabled writable registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scratch  <= 32'd0;
      prescale <= PRESCALE_DEFAULT;
    end else begin
      if (wr_scratch)  scratch  <= merge_bytes(scratch, writedata, byteenable);
      if (wr_prescale) prescale <= merge_bytes(prescale, writedata, byteenable);
    end
  end

  // Registered read path; an UPTIME_LO read snapshots the matching high word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readdata      <= 32'd0;
      readdatavalid <= 1'b0;
      hi_shadow     <= 32'd0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_mux;
      if (read && (address == ADDR_UP_LO)) hi_shadow <= uptime[63:32];
    end
  end

endmodule

// File: tb/tb_first_nios2_system_sysinfo.sv
// Self-checking bench for first_nios2_system_sysinfo with a behavioural model.
module tb_first_nios2_system_sysinfo;

  localparam logic [31:0] SYS_ID   = 32'h0000_0000;
  localparam logic [31:0] TSTAMP   = 32'd1521037506;
  localparam logic [31:0] PRE_DEF  = 32'd0;

  logic        clock;
  logic        reset;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  int n_checks = 0;
  int n_errors = 0;

  first_nios2_system_sysinfo #(
    .SYSTEM_ID(SYS_ID), .TIMESTAMP(TSTAMP), .PRESCALE_DEFAULT(PRE_DEF)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .readdatavalid(readdatavalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state.
  logic [63:0] m_up;
  logic [31:0] m_pc, m_pre, m_scr, m_hi, exp_rd;
  logic        m_en, exp_valid;
  logic [63:0] bd_val = 64'd0;
  int          bd_seq = 0;
  int          bd_seen = 0;

  // Model: uptime counts one per PRESCALE+1 enabled clocks; reads see pre-edge state.
  always @(posedge clock or posedge reset) begin : model
    logic [63:0] up;
    logic [31:0] pc;
    logic        ctrl_wr, en_n;
    logic [31:0] s, p;
    if (reset) begin
      m_up <= 64'd0; m_pc <= 32'd0; m_pre <= PRE_DEF; m_scr <= 32'd0;
      m_hi <= 32'd0; m_en <= 1'b1; exp_rd <= 32'd0; exp_valid <= 1'b0;
    end else begin
      up = (bd_seq != bd_seen) ? bd_val : m_up;
      bd_seen <= bd_seq;
      exp_valid <= read;
      if (read) begin
        case (address)
          3'd0: exp_rd <= SYS_ID;
          3'd1: exp_rd <= TSTAMP;
          3'd2: exp_rd <= up[31:0];
          3'd3: exp_rd <= m_hi;
          3'd4: exp_rd <= m_scr;
          3'd5: exp_rd <= {31'd0, m_en};
          3'd6: exp_rd <= m_pre;
          default: exp_rd <= 32'd0;
        endcase
        if (address == 3'd2) m_hi <= up[63:32];
      end
      ctrl_wr = write && (address == 3'd5) && byteenable[0];
      en_n = ctrl_wr ? writedata[0] : m_en;
      pc = m_pc;
      if (ctrl_wr && writedata[1]) begin
        up = 64'd0; pc = 32'd0;
      end else begin
        if (en_n) begin
          if (pc == m_pre) begin up = up + 64'd1; pc = 32'd0; end
          else pc = pc + 32'd1;
        end
        if (write && (address == 3'd6)) pc = 32'd0;
      end
      s = m_scr; p = m_pre;
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b] && write && (address == 3'd4)) s[8*b +: 8] = writedata[8*b +: 8];
        if (byteenable[b] && write && (address == 3'd6)) p[8*b +: 8] = writedata[8*b +: 8];
      end
      m_up <= up; m_pc <= pc; m_en <= en_n; m_scr <= s; m_pre <= p;
    end
  end

  // Bus drivers: called at a negedge, return at the negedge after the sampling edge.
  task automatic bus_read(input logic [2:0] a);
    address = a; read = 1'b1;
    @(negedge clock);
    read = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; write = 1'b1; writedata = d; byteenable = be;
    @(negedge clock);
    write = 1'b0; byteenable = 4'h0;
  endtask

  task automatic test_reset;
    logic [31:0] expc [8];
    expc[0] = SYS_ID; expc[1] = TSTAMP; expc[2] = 32'd0; expc[3] = 32'd0;
    expc[4] = 32'd0;  expc[5] = 32'd1;  expc[6] = PRE_DEF; expc[7] = 32'd0;
    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if (readdata !== 32'd0 || readdatavalid !== 1'b0) begin
      n_errors++; $display("FAIL reset_outputs: rd=%h v=%b required rd=0 v=0", readdata, readdatavalid);
    end
    reset = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        n_checks++;
        if (readdatavalid !== 1'b1 || readdata !== exp_rd) begin
          n_errors++; $display("FAIL reset_b2b_model a=%0d: rd=%h v=%b required rd=%h v=1", i-1, readdata, readdatavalid, exp_rd);
        end
        if (i != 3) begin
          n_checks++;
          if (readdata !== expc[i-1]) begin
            n_errors++; $display("FAIL reset_b2b_const a=%0d: rd=%h required %h", i-1, readdata, expc[i-1]);
          end
        end
      end
      if (i < 8) begin address = 3'(i); read = 1'b1; end
      else read = 1'b0;
      @(negedge clock);
    end
    n_checks++;
    if (readdatavalid !== 1'b0) begin
      n_errors++; $display("FAIL reset_b2b_valid_drop: v=%b required 0", readdatavalid);
    end
  endtask

  task automatic test_scratch;
    logic [31:0] ro_exp [3];
    logic [2:0]  ro_adr [3];
    ro_adr[0] = 3'd0; ro_adr[1] = 3'd1; ro_adr[2] = 3'd7;
    ro_exp[0] = SYS_ID; ro_exp[1] = TSTAMP; ro_exp[2] = 32'd0;
    bus_write(3'd4, 32'hDEADBEEF, 4'hF);
    bus_write(3'd4, 32'h0000_0055, 4'b0001);
    bus_read(3'd4);
    n_checks++;
    if (readdata !== 32'hDEADBE55 || readdata !== exp_rd) begin
      n_errors++; $display("FAIL scratch_be: rd=%h required DEADBE55 (model %h)", readdata, exp_rd);
    end
    for (int i = 0; i < 3; i++) begin
      bus_write(ro_adr[i], $urandom, 4'hF);
      bus_read(ro_adr[i]);
      n_checks++;
      if (readdata !== ro_exp[i]) begin
        n_errors++; $display("FAIL ro_write a=%0d: rd=%h required %h", ro_adr[i], readdata, ro_exp[i]);
      end
    end
  endtask

  task automatic test_prescale;
    logic [31:0] frozen;
    bus_write(3'd6, 32'd3, 4'hF);
    bus_write(3'd5, 32'h3, 4'hF);
    repeat (40) @(posedge clock);
    @(negedge clock);
    bus_read(3'd2);
    n_checks++;
    if (readdata !== 32'd10 || readdata !== exp_rd) begin
      n_errors++; $display("FAIL prescale_40clk: rd=%0d required 10 (model %0d)", readdata, exp_rd);
    end
    bus_write(3'd5, 32'h0, 4'hF);
    repeat (20) @(negedge clock);
    bus_read(3'd2);
    frozen = readdata;
    n_checks++;
    if (readdata !== 32'd10 || readdata !== exp_rd) begin
      n_errors++; $display("FAIL en_hold: rd=%0d required 10 (model %0d)", readdata, exp_rd);
    end
    bus_write(3'd5, 32'h1, 4'hF);
    repeat (20) @(negedge clock);
    bus_read(3'd2);
    n_checks++;
    if (readdata !== exp_rd || readdata <= frozen) begin
      n_errors++; $display("FAIL en_resume: rd=%0d required %0d", readdata, exp_rd);
    end
  endtask

  task automatic test_wrap;
    bus_write(3'd6, 32'd0, 4'hF);
    bd_val = 64'h0000_0000_FFFF_FFF0; bd_seq++;
    force dut.uptime = bd_val;
    #1 release dut.uptime;
    repeat (14) @(posedge clock);
    @(negedge clock);
    bus_read(3'd2);
    n_checks++;
    if (readdata !== 32'hFFFF_FFFE || readdata !== exp_rd) begin
      n_errors++; $display("FAIL wrap_lo: rd=%h required FFFFFFFE (model %h)", readdata, exp_rd);
    end
    bus_read(3'd3);
    n_checks++;
    if (readdata !== 32'd0 || readdata !== exp_rd) begin
      n_errors++; $display("FAIL wrap_hi_shadow: rd=%h required 0", readdata);
    end
    bd_val = 64'hFFFF_FFFF_FFFF_FFFA; bd_seq++;
    force dut.uptime = bd_val;
    #1 release dut.uptime;
    repeat (6) @(posedge clock);
    @(negedge clock);
    bus_read(3'd2);
    n_checks++;
    if (readdata !== 32'd0 || readdata !== exp_rd) begin
      n_errors++; $display("FAIL wrap64_lo: rd=%h required 0 (model %h)", readdata, exp_rd);
    end
    bus_read(3'd3);
    n_checks++;
    if (readdata !== 32'd0 || readdata !== exp_rd) begin
      n_errors++; $display("FAIL wrap64_hi: rd=%h required 0", readdata);
    end
  endtask

  task automatic test_clr_tick;
    bus_write(3'd6, 32'd3, 4'hF);
    repeat (3) @(posedge clock);
    @(negedge clock);
    bus_write(3'd5, 32'h3, 4'hF);
    bus_read(3'd2);
    n_checks++;
    if (readdata !== 32'd0 || readdata !== exp_rd) begin
      n_errors++; $display("FAIL clr_on_tick: rd=%0d required 0", readdata);
    end
    repeat (8) @(posedge clock);
    @(negedge clock);
    bus_read(3'd2);
    n_checks++;
    if (readdata !== 32'd2 || readdata !== exp_rd) begin
      n_errors++; $display("FAIL clr_then_count: rd=%0d required 2 (model %0d)", readdata, exp_rd);
    end
  endtask

  task automatic test_back_to_back;
    address = 3'd4; read = 1'b1; write = 1'b1; writedata = 32'h1234_5678; byteenable = 4'hF;
    @(negedge clock);
    read = 1'b0; write = 1'b0; byteenable = 4'h0;
    n_checks++;
    if (readdata !== 32'hDEADBE55 || readdata !== exp_rd) begin
      n_errors++; $display("FAIL rw_same_cycle: rd=%h required DEADBE55", readdata);
    end
    bus_read(3'd4);
    n_checks++;
    if (readdata !== 32'h1234_5678) begin
      n_errors++; $display("FAIL rw_after: rd=%h required 12345678", readdata);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      address = 3'($urandom_range(0, 7));
      read = 1'($urandom);
      write = ($urandom_range(0, 3) == 0);
      byteenable = 4'($urandom);
      writedata = (address == 3'd6) ? 32'($urandom_range(0, 5)) : $urandom;
      if (address == 3'd5) writedata[1] = ($urandom_range(0, 7) == 0);
      @(negedge clock);
      n_checks++;
      if (readdatavalid !== exp_valid || readdata !== exp_rd) begin
        n_errors++; $display("FAIL random cyc=%0d: rd=%h v=%b required rd=%h v=%b", i, readdata, readdatavalid, exp_rd, exp_valid);
      end
    end
    read = 1'b0; write = 1'b0; byteenable = 4'h0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid;
    logic [31:0] expc [8];
    expc[0] = SYS_ID; expc[1] = TSTAMP; expc[4] = 32'd0; expc[5] = 32'd1;
    expc[6] = PRE_DEF; expc[7] = 32'd0; expc[2] = 32'd0; expc[3] = 32'd0;
    bus_write(3'd4, 32'hA5A5_A5A5, 4'hF);
    bus_write(3'd6, 32'd9, 4'hF);
    bus_write(3'd5, 32'h0, 4'hF);
    address = 3'd4; read = 1'b1;
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      read = 1'b0;
      n_checks++;
      if (readdatavalid !== 1'b0 || readdata !== 32'd0) begin
        n_errors++; $display("FAIL reset_mid_drop c=%0d: v=%b rd=%h required v=0 rd=0", i, readdatavalid, readdata);
      end
    end
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a));
      n_checks++;
      if (readdatavalid !== 1'b1 || readdata !== exp_rd || (a != 2 && readdata !== expc[a])) begin
        n_errors++; $display("FAIL reset_mid_regs a=%0d: rd=%h required %h", a, readdata, (a == 2) ? exp_rd : expc[a]);
      end
    end
  endtask

  initial begin
    reset = 1'b0; address = 3'd0; read = 1'b0; write = 1'b0;
    writedata = 32'd0; byteenable = 4'h0;
    test_reset;
    test_scratch;
    test_prescale;
    test_wrap;
    test_clr_tick;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
